// File: rtl/inst_fetch_dual_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_dual_pkg
// Shared definitions for the dual-issue fetch stage: architectural widths,
// well-known instruction encodings, the PC increment and the fetch-queue entry.
// -----------------------------------------------------------------------------
package inst_fetch_dual_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] INST_HALT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_dual_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_dual_fetch_queue
// Circular buffer of {pc, inst} entries with 2-wide enqueue, 2-wide dequeue
// and a synchronous flush. Presents the head and head+1 entries directly from
// the storage registers.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          discard all entries this cycle (enqueue/dequeue ignored)
//   enq_cnt        number of entries written this cycle (0..2)
//   enq0, enq1     entries written at tail, tail+1
//   deq_cnt        entries consumed from head this cycle (clamped to occupancy)
//   count          current occupancy (0..QDEPTH)
//   head0, head1   entries at head, head+1 (meaningful only when count covers them)
// -----------------------------------------------------------------------------
module inst_fetch_dual_fetch_queue
  import inst_fetch_dual_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               enq_cnt,
  input  fetch_entry_t             enq0,
  input  fetch_entry_t             enq1,
  input  logic [1:0]               deq_cnt,
  output logic [$clog2(QDEPTH):0]  count,
  output fetch_entry_t             head0,
  output fetch_entry_t             head1
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [QDEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [1:0]      deq_eff;

  // Never retire more than the two visible entries nor more than are present.
  always_comb begin
    deq_eff = (deq_cnt > 2'd2) ? 2'd2 : deq_cnt;
    if (CW'(deq_eff) > count) deq_eff = count[1:0];
  end

  // Pointers and occupancy: power-of-two depth lets the pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(deq_eff);
      wr_ptr <= wr_ptr + AW'(enq_cnt);
      count  <= count + CW'(enq_cnt) - CW'(deq_eff);
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (enq_cnt != 2'd0) mem[wr_ptr]          <= enq0;
      if (enq_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= enq1;
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

  // Decode must never ask for more than it was shown.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (CW'(deq_cnt) <= count)
        else $error("fetch_queue: deq_cnt %0d exceeds occupancy %0d", deq_cnt, count);
    end
  end

endmodule

// File: rtl/inst_fetch_dual.sv
// -----------------------------------------------------------------------------
// inst_fetch_dual
// Dual-issue instruction fetch stage. Drives pc and pc+4 into a combinational
// instruction memory, buffers the returned words with their PCs and presents
// up to two in-order instructions to decode. Handles redirect (highest
// priority), decode backpressure via free-slot accounting, and optional halt
// detection.
//
// Build option: define FETCH_HALT_EN to treat an all-zero fetched word as a
// halt marker; when undefined, zero words are ordinary instructions and
// halted is tied low.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_addr0/1          fetch addresses pc, pc+4 (mod 2^32)
//   imem_inst0/1          words at imem_addr0/1, valid the same cycle
//   redirect_valid/pc     flush and restart fetch at redirect_pc (word aligned)
//   deq_cnt               instructions taken by decode this cycle
//   out_valid             bit0 head valid, bit1 head+1 valid
//   out_inst0/1, out_pc0/1  head / head+1 instruction and PC
//   halted                fetch stopped on a halt word
// -----------------------------------------------------------------------------
module inst_fetch_dual
  import inst_fetch_dual_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr0,
  output logic [31:0] imem_addr1,
  input  logic [31:0] imem_inst0,
  input  logic [31:0] imem_inst1,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  deq_cnt,
  output logic [1:0]  out_valid,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic        halted
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [1:0]    enq_cnt;
  logic          fetch_en;
  fetch_entry_t  enq0;
  fetch_entry_t  enq1;
  fetch_entry_t  head0;
  fetch_entry_t  head1;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr0 = pc;
  assign imem_addr1 = pc + PC_STEP;

  // Pre-dequeue occupancy: slots freed by decode this cycle are not reused
  // until the next one, which keeps enqueue independent of deq_cnt timing.
  assign free = CW'(QDEPTH) - count;

`ifdef FETCH_HALT_EN
  logic halted_q;
  logic halt_set;
  assign fetch_en = !halted_q;
  assign halted   = halted_q;
`else
  assign fetch_en = 1'b1;
  assign halted   = 1'b0;
`endif

  always_comb begin
    enq_cnt = 2'd0;
    pc_next = pc;
`ifdef FETCH_HALT_EN
    halt_set = 1'b0;
`endif
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (fetch_en) begin
      if (free >= CW'(2)) begin
        enq_cnt = 2'd2;
        pc_next = pc + (PC_STEP << 1);
      end else if (free == CW'(1)) begin
        enq_cnt = 2'd1;
        pc_next = pc + PC_STEP;
      end
`ifdef FETCH_HALT_EN
      // A halt word is never enqueued; pc parks on it so a redirect is the
      // only way forward.
      if (enq_cnt != 2'd0 && imem_inst0 == INST_HALT) begin
        enq_cnt  = 2'd0;
        pc_next  = pc;
        halt_set = 1'b1;
      end else if (enq_cnt == 2'd2 && imem_inst1 == INST_HALT) begin
        enq_cnt  = 2'd1;
        pc_next  = pc + PC_STEP;
        halt_set = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted_q <= 1'b0;
    else if (redirect_valid) halted_q <= 1'b0;
    else if (halt_set)       halted_q <= 1'b1;
  end
`endif

  assign enq0 = '{pc: pc,         inst: imem_inst0};
  assign enq1 = '{pc: imem_addr1, inst: imem_inst1};

  // ---- fetch -> queue boundary: outputs below come from queue registers ----
  inst_fetch_dual_fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .enq_cnt (enq_cnt),
    .enq0    (enq0),
    .enq1    (enq1),
    .deq_cnt (deq_cnt),
    .count   (count),
    .head0   (head0),
    .head1   (head1)
  );

  assign out_valid = {count >= CW'(2), count >= CW'(1)};
  assign out_inst0 = head0.inst;
  assign out_inst1 = head1.inst;
  assign out_pc0   = head0.pc;
  assign out_pc1   = head1.pc;

endmodule
